seq_mul: RTL and testbench

Parametrised sequential shift-add multiplier with per-transaction signed/unsigned mode and valid/ready handshakes on both input and output. It replaces the fixed 8x8 unsigned combinational array multiplier where area matters more than throughput, such as weight × pixel products in the edge-preserving filter datapath. It computes one WIDTH×WIDTH product every WIDTH+2 cycles and produces a full 2·WIDTH-bit result.

---
 rtl/seq_mul.sv | 110 +++++++++++
 tb/tb_seq_mul.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: one WIDTH x WIDTH product (signed or unsigned
// per transaction) every WIDTH+2 cycles, with valid/ready handshakes on both sides.
module seq_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic                 i_signed,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [2*WIDTH-1:0]   o_p
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic               r_neg;
    logic [PW-1:0]      r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [PW-1:0]      r_p;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_last;
    logic               w_bit;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [PW-1:0]      w_partial;
    logic [PW-1:0]      w_sum;
    logic [PW-1:0]      w_prod;

    assign o_in_ready  = i_rst_n && (r_state == S_IDLE);
    assign o_out_valid = r_out_valid;
    assign o_p         = r_p;

    assign w_accept = i_in_valid && o_in_ready;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Operands are reduced to magnitudes; the sign is reapplied once at the end.
    assign w_mag_a = (i_signed && i_a[WIDTH-1]) ? WIDTH'(-i_a) : i_a;
    assign w_mag_b = (i_signed && i_b[WIDTH-1]) ? WIDTH'(-i_b) : i_b;

    assign w_bit     = |(r_mag_b & (WIDTH'(1) << r_cnt));
    assign w_partial = w_bit ? (PW'(r_mag_a) << r_cnt) : '0;
    assign w_sum     = r_acc + w_partial;
    assign w_prod    = r_neg ? PW'(-w_sum) : w_sum;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)    w_state_nxt = S_CALC;
            S_CALC:  if (w_last)      w_state_nxt = S_DONE;
            S_DONE:  if (i_out_ready) w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_mag_a     <= '0;
            r_mag_b     <= '0;
            r_neg       <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_p         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mag_a <= w_mag_a;
                        r_mag_b <= w_mag_b;
                        r_neg   <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_p         <= w_prod;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) r_out_valid <= 1'b0;
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// Directed and randomised checks of seq_mul at WIDTH=8 and WIDTH=12.
module tb_seq_mul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid8, in_ready8, s8, out_valid8, out_ready8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        in_valid12, in_ready12, s12, out_valid12, out_ready12;
    logic [11:0] a12, b12;
    logic [23:0] p12;

    int n_tests = 0;
    int n_fail  = 0;

    seq_mul #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid8), .o_in_ready(in_ready8),
        .i_a(a8), .i_b(b8), .i_signed(s8), .o_out_valid(out_valid8),
        .i_out_ready(out_ready8), .o_p(p8)
    );

    seq_mul #(.WIDTH(12)) dut12 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid12), .o_in_ready(in_ready12),
        .i_a(a12), .i_b(b12), .i_signed(s12), .o_out_valid(out_valid12),
        .i_out_ready(out_ready12), .o_p(p12)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the selected instance with out_ready held high.
    task automatic txn(input bit w12, input logic [11:0] a, input logic [11:0] b,
                       input logic s, input logic [23:0] exp, input int exp_lat,
                       input string name);
        int  lat;
        bit  got;
        if (w12) begin
            in_valid12 = 1'b1; a12 = a; b12 = b; s12 = s; out_ready12 = 1'b1;
        end else begin
            in_valid8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; s8 = s; out_ready8 = 1'b1;
        end
        check({name, "_ready"}, 32'(w12 ? in_ready12 : in_ready8), 32'd1);
        step();
        in_valid8  = 1'b0;
        in_valid12 = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            step();
            lat++;
            got = w12 ? out_valid12 : out_valid8;
        end
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_p"}, 32'(w12 ? p12 : {8'b0, p8}), 32'(exp));
        step();
        check({name, "_drop"}, 32'(w12 ? out_valid12 : out_valid8), 32'd0);
        check({name, "_idle"}, 32'(w12 ? in_ready12 : in_ready8), 32'd1);
    endtask

    initial begin
        logic [15:0] q[$];
        logic [15:0] exp_p;
        logic        acc, hs, stale;
        int          lat, done_n, acc_n, cyc, sa, sb;

        vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[1]  = '{8'hFF, 8'h05, 1'b1, 16'hFFFB};
        vecs[2]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[3]  = '{8'hFF, 8'h05, 1'b0, 16'h04FB};
        vecs[4]  = '{8'h03, 8'h04, 1'b0, 16'h000C};
        vecs[5]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[6]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[7]  = '{8'h00, 8'hFF, 1'b1, 16'h0000};
        vecs[8]  = '{8'h80, 8'h01, 1'b0, 16'h0080};
        vecs[9]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[10] = '{8'h80, 8'hFF, 1'b1, 16'h0080};

        rst_n = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; out_ready8 = 1'b0;
        in_valid12 = 1'b0; a12 = '0; b12 = '0; s12 = 1'b0; out_ready12 = 1'b0;
        step(); step(); step();
        check("rst_in_ready", 32'(in_ready8), 32'd0);
        check("rst_out_valid", 32'(out_valid8), 32'd0);
        check("rst_p", 32'(p8), 32'd0);
        check("rst_p12", 32'(p12), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready8), 32'd1);
        step();

        for (int i = 0; i < 11; i++)
            txn(1'b0, {4'b0, vecs[i].a}, {4'b0, vecs[i].b}, vecs[i].s, {8'b0, vecs[i].p}, 8,
                $sformatf("vec%0d", i));

        // Backpressure: DONE holds while new operands wait on in_valid.
        in_valid8 = 1'b1; a8 = 8'h12; b8 = 8'h34; s8 = 1'b0; out_ready8 = 1'b0;
        step();
        a8 = 8'h05; b8 = 8'h06;
        lat = 0;
        while (!out_valid8 && lat < 40) begin step(); lat++; end
        check("bp_lat", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_p%0d", i), 32'(p8), 32'h03A8);
            check($sformatf("bp_rdy%0d", i), 32'(in_ready8), 32'd0);
            check($sformatf("bp_vld%0d", i), 32'(out_valid8), 32'd1);
            step();
        end
        out_ready8 = 1'b1;
        step();
        check("bp_hs_vld", 32'(out_valid8), 32'd0);
        check("bp_hs_rdy", 32'(in_ready8), 32'd1);
        step();
        check("bp_next_acc", 32'(in_ready8), 32'd0);
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 40) begin step(); lat++; end
        check("bp_next_lat", 32'(lat), 32'd8);
        check("bp_next_p", 32'(p8), 32'h001E);
        step();

        // Reset in the middle of a computation discards it.
        in_valid8 = 1'b1; a8 = 8'h7F; b8 = 8'h7F; s8 = 1'b0; out_ready8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        step();
        check("midrst_vld", 32'(out_valid8), 32'd0);
        check("midrst_p", 32'(p8), 32'd0);
        check("midrst_rdy", 32'(in_ready8), 32'd0);
        rst_n = 1'b1;
        #1;
        check("midrst_rel_rdy", 32'(in_ready8), 32'd1);
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            stale = stale | out_valid8;
        end
        check("midrst_stale", 32'(stale), 32'd0);
        txn(1'b0, 12'd3, 12'd4, 1'b0, 24'h00000C, 8, "midrst_next");

        txn(1'b1, 12'hFFF, 12'hFFF, 1'b0, 24'hFFE001, 12, "w12_umax");
        txn(1'b1, 12'h800, 12'h001, 1'b1, 24'hFFF800, 12, "w12_sneg");
        txn(1'b1, 12'h800, 12'h800, 1'b1, 24'h400000, 12, "w12_smin");

        // Random traffic with gaps on both sides, scoreboarded in order.
        in_valid8 = 1'b0; out_ready8 = 1'b0;
        done_n = 0; acc_n = 0; cyc = 0;
        while (done_n < 300 && cyc < 20000) begin
            acc = in_valid8 && in_ready8;
            hs  = out_valid8 && out_ready8;
            if (hs) begin
                done_n++;
                if (q.size() == 0) check("rnd_extra", 32'(q.size()), 32'd1);
                else check($sformatf("rnd_p%0d", done_n), 32'(p8), 32'(q.pop_front()));
            end
            if (acc) begin
                acc_n++;
                sa = s8 ? int'($signed(a8)) : int'({24'b0, a8});
                sb = s8 ? int'($signed(b8)) : int'({24'b0, b8});
                exp_p = 16'(sa * sb);
                q.push_back(exp_p);
            end
            step();
            cyc++;
            if (acc) in_valid8 = 1'b0;
            if (!in_valid8 && $urandom_range(0, 2) == 0) begin
                a8 = 8'($urandom_range(0, 255));
                b8 = 8'($urandom_range(0, 255));
                s8 = 1'($urandom_range(0, 1));
                in_valid8 = 1'b1;
            end
            out_ready8 = 1'($urandom_range(0, 1));
        end
        check("rnd_done", 32'(done_n), 32'd300);
        check("rnd_balance", 32'(acc_n), 32'(done_n));
        check("rnd_queue", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
